lsu_ctrl: RTL

LSU_CTRL -- requirements
Module: lsu_ctrl

---
 rtl/lsu_ctrl.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/lsu_ctrl.sv
// Load/store unit controller: one request at a time toward a word memory.
// Optional LSU_MISALIGN_EN splits misaligned accesses into byte accesses.
module lsu_ctrl (
   input  logic        clk,
   input  logic        rstn,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_wr,
   input  logic [2:0]  req_type,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic        mem_wr_en,
   output logic [2:0]  mem_rw_type,
   output logic [31:0] mem_data_addr,
   output logic [31:0] mem_data_in,
   input  logic [31:0] mem_data_out
);

   typedef struct packed {
      logic        wr;
      logic [2:0]  typ;
      logic [31:0] addr;
      logic [31:0] wdata;
   } lsu_req_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
`ifdef LSU_MISALIGN_EN
      SPLIT  = 2'd2,
`endif
      RESP   = 2'd3
   } state_t;

   state_t      state;
   state_t      state_n;
   lsu_req_t    req_q;
   logic [31:0] rdata;
   logic        misal;
   logic        active;
   logic [2:0]  type_h;
   logic [31:0] addr_h;
   logic [31:0] data_h;

`ifdef LSU_MISALIGN_EN
   logic [1:0]  cnt;
   logic        half;
   logic        last;

   assign half = (req_q.typ[1:0] == 2'b01);
   assign last = (cnt == (half ? 2'd1 : 2'd3));
`else
   logic        err_q;
`endif

   always_comb begin
      misal = 1'b0;
      unique case (1'b1)
         (req_type[1:0] == 2'b00): misal = 1'b0;
         (req_type[1:0] == 2'b01): misal = req_addr[0];
         default:                  misal = |req_addr[1:0];
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstn) state <= IDLE;
      else       state <= state_n;
   end

   always_comb begin
      state_n = state;
      case (state)
         IDLE: begin
            if (req_valid) begin
               if (!misal) state_n = ACCESS;
`ifdef LSU_MISALIGN_EN
               else        state_n = SPLIT;
`else
               else        state_n = RESP;
`endif
            end
         end
         ACCESS: state_n = RESP;
`ifdef LSU_MISALIGN_EN
         SPLIT: if (last) state_n = RESP;
`endif
         RESP:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

`ifdef LSU_MISALIGN_EN
   assign active = (state == ACCESS) || (state == SPLIT);
`else
   assign active = (state == ACCESS);
`endif

   // Memory port shows the live access, otherwise the last one driven.
   always_comb begin
      mem_data_addr = addr_h;
      mem_rw_type   = type_h;
      mem_data_in   = data_h;
      if (state == ACCESS) begin
         mem_data_addr = req_q.addr;
         mem_rw_type   = req_q.typ;
         mem_data_in   = req_q.wdata;
      end
`ifdef LSU_MISALIGN_EN
      else if (state == SPLIT) begin
         mem_data_addr = req_q.addr + {30'd0, cnt};
         mem_rw_type   = 3'b100;
         mem_data_in   = req_q.wdata >> {cnt, 3'b000};
      end
`endif
   end

   // Gating with rstn keeps a reset edge from landing a write.
   assign mem_wr_en = active & req_q.wr & rstn;

   always_ff @(posedge clk) begin
      if (!rstn) begin
         addr_h <= '0;
         type_h <= '0;
         data_h <= '0;
      end else if (active) begin
         addr_h <= mem_data_addr;
         type_h <= mem_rw_type;
         data_h <= mem_data_in;
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         req_q <= '0;
         rdata <= '0;
`ifdef LSU_MISALIGN_EN
         cnt   <= '0;
`else
         err_q <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  req_q <= '{req_wr, req_type, req_addr, req_wdata};
                  rdata <= '0;
`ifdef LSU_MISALIGN_EN
                  cnt   <= '0;
`else
                  err_q <= misal;
`endif
               end
            end
            ACCESS: rdata <= mem_data_out;
`ifdef LSU_MISALIGN_EN
            SPLIT: begin
               cnt <= cnt + 2'd1;
               if (!req_q.wr) begin
                  rdata[{cnt, 3'b000} +: 8] <= mem_data_out[7:0];
                  if (last && half)
                     rdata[31:16] <=
                        {16{~req_q.typ[2] & mem_data_out[7]}};
               end
            end
`endif
            default: ;
         endcase
      end
   end

   assign req_ready  = (state == IDLE);
   assign resp_valid = (state == RESP);

`ifdef LSU_MISALIGN_EN
   assign resp_err   = 1'b0;
   assign resp_rdata = (resp_valid && !req_q.wr) ? rdata : 32'd0;
`else
   assign resp_err   = resp_valid & err_q;
   assign resp_rdata = (resp_valid && !req_q.wr && !err_q) ?
                       rdata : 32'd0;
`endif

endmodule
